quick_spi_arbiter: RTL and testbench
====================================

# quick_spi_arbiter

Round-robin arbiter and sequencer that shares one `quick_spi_hard` SPI master among several client requesters. It accepts one transaction request at a time, drives the master's `enable`, `start_transaction`, `slave`, `operation` and `outgoing_data` inputs, and waits for `end_of_transaction`. It then returns the read data to the granted requester and enforces the master's post-transaction recovery window before the next grant. It sits between the system's peripheral drivers and the single SPI master instance.

## Interface
- `NUM_REQUESTERS`, 4: number of client ports (2..8).
- `NUMBER_OF_SLAVES`, 4: width of the master's one-hot `slave` bus.
- `SLAVE_INDEX_WIDTH`, 2: width of each requester's slave index field.
- `INCOMING_DATA_WIDTH`, 8: matches the master.
- `OUTGOING_DATA_WIDTH`, 16: matches the master.
- `GUARD_CYCLES`, 52: idle cycles after `end_of_transaction` before the next `start_transaction`. Must cover the master's 51-cycle WAIT state.
- `TIMEOUT_CYCLES`, 4096: watchdog limit in BUSY; used only with the macro.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in N: per-requester request.
- `req_ready` out N: one-hot grant; the handshake completes in the cycle where `req_valid[i] & req_ready[i]`.
- `req_operation` in N: per requester, 0 = READ, 1 = WRITE.
- `req_slave` in N*SLAVE_INDEX_WIDTH: packed slave indices; requester i occupies slice [i*W +: W].
- `req_data` in N*OUTGOING_DATA_WIDTH: packed write data.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_id` out 3: index of the completed requester.
- `rsp_data` out INCOMING_DATA_WIDTH: read data; zero for WRITE and on error.
- `rsp_error` out 1: qualifies `rsp_valid`.
- `busy` out 1: high in any state other than IDLE.
- `spi_enable` out 1: drives master `enable`.
- `spi_start_transaction` out 1: drives master `start_transaction`.
- `spi_slave` out NUMBER_OF_SLAVES: drives master `slave`.
- `spi_operation` out 1: drives master `operation`.
- `spi_outgoing_data` out OUTGOING_DATA_WIDTH: drives master `outgoing_data`.
- `spi_end_of_transaction` in 1: from master.
- `spi_incoming_data` in INCOMING_DATA_WIDTH: from master.

## Operation
- **States:** IDLE, ISSUE, BUSY, RESP, GUARD.
- **IDLE:**
  - Combinationally picks the first asserted `req_valid` starting from `rr_ptr` and wrapping modulo N.
  - Asserts `req_ready` for that requester only.
  - On the handshake, latches the requester index, operation, slave index and data.
  - `rr_ptr` becomes (grant+1) mod N, and the state goes to ISSUE.
  - With no requests, `rr_ptr` is unchanged.
- **Slave index check:** if the latched index is ≥ NUMBER_OF_SLAVES, go to RESP with `rsp_error`=1 and no SPI activity.
- **ISSUE:**
  - `spi_start_transaction`=1 for exactly one cycle.
  - `spi_slave` is the one-hot decode of the index.
  - `spi_operation` and `spi_outgoing_data` come from the latched values.
  - Next state is BUSY.
- **BUSY:**
  - `spi_slave`, `spi_operation` and `spi_outgoing_data` are held stable, because the master samples `operation` and `slave` throughout the transaction.
  - On `spi_end_of_transaction`=1, latch `spi_incoming_data` (READ) or zero (WRITE), then go to RESP.
- **RESP:**
  - `rsp_valid`=1 for one cycle with `rsp_id`, `rsp_data` and `rsp_error`.
  - Next state is GUARD, or IDLE for an error that had no SPI activity.
- **GUARD:**
  - The counter counts from 0 to GUARD_CYCLES−1, then the state goes to IDLE.
  - `spi_slave` returns to 0 on entry.
- **`spi_enable`:** 1 in every state after reset.
- **`end_of_transaction` outside BUSY:** ignored.
- **Requester data:** requesters keep `req_*` stable only until their handshake.

## Timing
- **Reset values:**
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_error`=0, `busy`=0.
  - `spi_enable`=0, `spi_start_transaction`=0, `spi_slave`=0, `spi_operation`=0, `spi_outgoing_data`=0.
  - `rr_ptr`=0, state IDLE.
  - `spi_enable` rises in the first cycle after `reset` deasserts.
- **Handshake to start:** 1 cycle (handshake in cycle T, `spi_start_transaction` high in T+1).
- **End to response:** `end_of_transaction` in cycle E gives `rsp_valid` in E+1.
- **Earliest next handshake:** cycle E+2+GUARD_CYCLES.
- **Simultaneous requests:** resolved purely by `rr_ptr`. A requester that keeps `req_valid` high is served at most once per N grants while others are pending.
- **Deasserted request:** a requester dropping `req_valid` before the handshake is simply not granted.
- **Reset mid-transaction:** returns to IDLE within one cycle with all outputs at reset values. No response is generated; the master must be reset alongside.

## Configuration
- **`QUICK_SPI_ARBITER_TIMEOUT_EN` defined:**
  - The BUSY watchdog counts cycles.
  - At TIMEOUT_CYCLES without `end_of_transaction`, the block goes to RESP with `rsp_error`=1 and `rsp_data`=0, then GUARD.
  - The counter clears on BUSY entry.
- **Undefined:**
  - No watchdog logic.
  - BUSY waits indefinitely.
  - `rsp_error` flags only a bad slave index.
  - The TIMEOUT_CYCLES parameter is unused.

## Test plan
- **Single write:** requester 0 writes 0xA55A to slave 1 -> one `spi_start_transaction` pulse, `spi_slave`=4'b0010 held until `end_of_transaction`, then `rsp_valid` with `rsp_id`=0, `rsp_data`=0, `rsp_error`=0.
- **Single read:** requester 2 reads slave 3 while the model master returns 0x3C -> `rsp_data`=0x3C, `rsp_id`=2, one cycle after `end_of_transaction`.
- **Round-robin:** all 4 requesters held valid from reset -> grant order 0,1,2,3,0. Consecutive starts are separated by at least GUARD_CYCLES+2 cycles after each end.
- **Bad slave index:** `req_slave`=3 with NUMBER_OF_SLAVES=3 -> no `spi_start_transaction`, `rsp_valid` with `rsp_error`=1 two cycles after the handshake.
- **Reset mid-BUSY:** `reset` asserted during BUSY -> next cycle `busy`=0, `spi_slave`=0, no `rsp_valid`, and the following grant goes to requester 0.
- **Timeout (with macro, TIMEOUT_CYCLES=100):** master never ends -> `rsp_valid` with `rsp_error`=1 after 100 BUSY cycles.

Source files
------------

// File: rtl/quick_spi_arbiter.sv
// rtl/quick_spi_arbiter.sv - round-robin arbiter sequencing requesters onto one quick_spi_hard master
// Optional BUSY watchdog enabled by defining QUICK_SPI_ARBITER_TIMEOUT_EN.
module quick_spi_arbiter #(
    parameter int NUM_REQUESTERS      = 4,
    parameter int NUMBER_OF_SLAVES    = 4,
    parameter int SLAVE_INDEX_WIDTH   = 2,
    parameter int INCOMING_DATA_WIDTH = 8,
    parameter int OUTGOING_DATA_WIDTH = 16,
    parameter int GUARD_CYCLES        = 52,
    parameter int TIMEOUT_CYCLES      = 4096
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_REQUESTERS-1:0]                     req_valid,
    output logic [NUM_REQUESTERS-1:0]                     req_ready,
    input  logic [NUM_REQUESTERS-1:0]                     req_operation,
    input  logic [NUM_REQUESTERS*SLAVE_INDEX_WIDTH-1:0]   req_slave,
    input  logic [NUM_REQUESTERS*OUTGOING_DATA_WIDTH-1:0] req_data,
    output logic                                          rsp_valid,
    output logic [2:0]                                    rsp_id,
    output logic [INCOMING_DATA_WIDTH-1:0]                rsp_data,
    output logic                                          rsp_error,
    output logic                                          busy,
    output logic                                          spi_enable,
    output logic                                          spi_start_transaction,
    output logic [NUMBER_OF_SLAVES-1:0]                   spi_slave,
    output logic                                          spi_operation,
    output logic [OUTGOING_DATA_WIDTH-1:0]                spi_outgoing_data,
    input  logic                                          spi_end_of_transaction,
    input  logic [INCOMING_DATA_WIDTH-1:0]                spi_incoming_data
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_BUSY, S_RESP, S_GUARD} state_t;

`ifdef QUICK_SPI_ARBITER_TIMEOUT_EN
    localparam int CNT_MAX = (GUARD_CYCLES > TIMEOUT_CYCLES) ? GUARD_CYCLES : TIMEOUT_CYCLES;
`else
    // TIMEOUT_CYCLES has no effect without the watchdog
    localparam int CNT_MAX = GUARD_CYCLES + 0 * TIMEOUT_CYCLES;
`endif
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    state_t                         state_q, state_d;
    logic [2:0]                     rr_ptr_q, rr_ptr_d;
    logic [2:0]                     id_q, id_d;
    logic                           op_q, op_d;
    logic [SLAVE_INDEX_WIDTH-1:0]   slave_idx_q, slave_idx_d;
    logic [OUTGOING_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [INCOMING_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                           err_q, err_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           enable_q, enable_d;

    logic                           found;
    logic [2:0]                     grant_idx;
    logic                           bad_idx;
    logic [NUMBER_OF_SLAVES-1:0]    slave_oh;

    // First pass scans from rr_ptr upward, second pass wraps to the low indices.
    always_comb begin
        found     = 1'b0;
        grant_idx = 3'd0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (!found && req_valid[i] && (3'(i) >= rr_ptr_q)) begin
                found     = 1'b1;
                grant_idx = 3'(i);
            end
        end
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (!found && req_valid[i]) begin
                found     = 1'b1;
                grant_idx = 3'(i);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            req_ready[i] = (state_q == S_IDLE) && !reset && found && (grant_idx == 3'(i));
        end
    end

    always_comb begin
        slave_oh = '0;
        for (int i = 0; i < NUMBER_OF_SLAVES; i++) begin
            slave_oh[i] = (32'(slave_idx_q) == i);
        end
    end

    assign bad_idx = (32'(slave_idx_q) >= NUMBER_OF_SLAVES);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        op_d        = op_q;
        slave_idx_d = slave_idx_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        enable_d    = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    id_d     = grant_idx;
                    rr_ptr_d = (grant_idx == 3'(NUM_REQUESTERS - 1)) ? 3'd0 : grant_idx + 3'd1;
                    for (int i = 0; i < NUM_REQUESTERS; i++) begin
                        if (grant_idx == 3'(i)) begin
                            op_d        = req_operation[i];
                            slave_idx_d = req_slave[i*SLAVE_INDEX_WIDTH +: SLAVE_INDEX_WIDTH];
                            wdata_d     = req_data[i*OUTGOING_DATA_WIDTH +: OUTGOING_DATA_WIDTH];
                        end
                    end
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bad_idx) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (spi_end_of_transaction) begin
                    rdata_d = op_q ? '0 : spi_incoming_data;
                    state_d = S_RESP;
                end
`ifdef QUICK_SPI_ARBITER_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                cnt_d   = '0;
                // A rejected slave index never touched the master, so no recovery window.
                state_d = bad_idx ? S_IDLE : S_GUARD;
            end
            S_GUARD: begin
                if (cnt_q == CNT_W'(GUARD_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= 3'd0;
            id_q        <= 3'd0;
            op_q        <= 1'b0;
            slave_idx_q <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            enable_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            op_q        <= op_d;
            slave_idx_q <= slave_idx_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            enable_q    <= enable_d;
        end
    end

    assign busy                  = (state_q != S_IDLE);
    assign spi_enable            = enable_q;
    assign spi_start_transaction = (state_q == S_ISSUE) && !bad_idx;
    assign spi_slave             = ((state_q == S_ISSUE) || (state_q == S_BUSY)) ? slave_oh : '0;
    assign spi_operation         = op_q;
    assign spi_outgoing_data     = wdata_q;
    assign rsp_valid             = (state_q == S_RESP);
    assign rsp_id                = (state_q == S_RESP) ? id_q : 3'd0;
    assign rsp_data              = (state_q == S_RESP) ? rdata_q : '0;
    assign rsp_error             = (state_q == S_RESP) && err_q;

endmodule

// File: tb/tb_quick_spi_arbiter.sv
// tb/tb_quick_spi_arbiter.sv - randomized self-checking bench for quick_spi_arbiter
module tb_quick_spi_arbiter;
    localparam int N  = 4;
    localparam int NS = 3;
    localparam int SW = 2;
    localparam int IW = 8;
    localparam int OW = 16;
    localparam int G  = 52;
    localparam int TO = 100;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_operation = '0;
    logic [N*SW-1:0] req_slave = '0;
    logic [N*OW-1:0] req_data = '0;
    logic            rsp_valid, rsp_error, busy;
    logic [2:0]      rsp_id;
    logic [IW-1:0]   rsp_data;
    logic            spi_enable, spi_start_transaction, spi_operation;
    logic [NS-1:0]   spi_slave;
    logic [OW-1:0]   spi_outgoing_data;
    logic            spi_end_of_transaction = 1'b0;
    logic [IW-1:0]   spi_incoming_data = '0;

    quick_spi_arbiter #(
        .NUM_REQUESTERS(N), .NUMBER_OF_SLAVES(NS), .SLAVE_INDEX_WIDTH(SW),
        .INCOMING_DATA_WIDTH(IW), .OUTGOING_DATA_WIDTH(OW),
        .GUARD_CYCLES(G), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_operation(req_operation),
        .req_slave(req_slave), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .busy(busy), .spi_enable(spi_enable), .spi_start_transaction(spi_start_transaction),
        .spi_slave(spi_slave), .spi_operation(spi_operation), .spi_outgoing_data(spi_outgoing_data),
        .spi_end_of_transaction(spi_end_of_transaction), .spi_incoming_data(spi_incoming_data)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          rr = 0;
    logic [N-1:0] arm_mask = '0;
    bit          m_op [N];
    int          m_slv [N];
    logic [OW-1:0] m_dat [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic arm(input int i, input bit op, input int slv, input logic [OW-1:0] d);
        req_operation[i]      = op;
        req_slave[i*SW +: SW] = slv[SW-1:0];
        req_data[i*OW +: OW]  = d;
        m_op[i]  = op;
        m_slv[i] = slv;
        m_dat[i] = d;
        arm_mask[i] = 1'b1;
    endtask

    task automatic arm_random_one();
        int s, i;
        s = $urandom_range(0, N - 1);
        for (int k = 0; k < N; k++) begin
            i = (s + k) % N;
            if (!req_valid[i] && !arm_mask[i]) begin
                arm(i, 1'($urandom_range(0, 1)), $urandom_range(0, 3), OW'($urandom));
                return;
            end
        end
    endtask

    task automatic apply_arms();
        req_valid = req_valid | arm_mask;
        arm_mask  = '0;
    endtask

    // One full transaction as the reference sees it: grant, issue, busy, response, guard.
    task automatic run_txn(input bit keep, input bit rnd, input bit abort, input bit to_mode, input int fdata);
        int g, lat, cur_slv;
        bit cur_op, bad;
        logic [OW-1:0] cur_dat;
        logic [IW-1:0] mdata;
        g = -1;
        for (int w = 0; w < 3 && g < 0; w++) begin
            @(negedge clk);
            spi_end_of_transaction = 1'b0;
            apply_arms();
            #1;
            g = pick(req_valid, rr);
            check("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
            check("busy_idle", busy, 0);
            check("rsp_idle", rsp_valid, 0);
            check("enable", spi_enable, 1);
            if (g < 0 && rnd) arm_random_one();
        end
        if (g < 0) return;
        rr = (g + 1) % N;
        cur_op = m_op[g]; cur_slv = m_slv[g]; cur_dat = m_dat[g];
        bad = (cur_slv >= NS);

        @(negedge clk);
        req_valid[g] = 1'b0;
        req_data[g*OW +: OW] = OW'($urandom);
        req_operation[g] = ~req_operation[g];
        if (keep) arm(g, 1'($urandom_range(0, 1)), $urandom_range(0, NS - 1), OW'($urandom));
        if (rnd && $urandom_range(0, 1) == 0) arm_random_one();
        apply_arms();
        #1;
        check("start", spi_start_transaction, bad ? 0 : 1);
        check("slave_issue", spi_slave, bad ? 0 : (1 << cur_slv));
        check("busy_issue", busy, 1);
        check("ready_issue", req_ready, 0);
        if (!bad) begin
            check("op_issue", spi_operation, cur_op);
            check("wdata_issue", spi_outgoing_data, cur_dat);
        end
        if (bad) begin
            @(negedge clk); #1;
            check("bad_rsp_valid", rsp_valid, 1);
            check("bad_rsp_error", rsp_error, 1);
            check("bad_rsp_id", rsp_id, g);
            check("bad_rsp_data", rsp_data, 0);
            check("bad_no_start", spi_start_transaction, 0);
            return;
        end
        if (abort) begin
            @(negedge clk); reset = 1'b1;
            @(negedge clk);
            req_valid = 4'b1110;
            #1;
            check("rst_busy", busy, 0);
            check("rst_slave", spi_slave, 0);
            check("rst_rsp", rsp_valid, 0);
            check("rst_ready", req_ready, 0);
            check("rst_enable", spi_enable, 0);
            check("rst_start", spi_start_transaction, 0);
            reset = 1'b0;
            req_valid = '0;
            rr = 0;
            return;
        end
        lat = to_mode ? TO : $urandom_range(1, 8);
        mdata = (fdata >= 0) ? IW'(fdata) : IW'($urandom);
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            if (c == lat - 1 && !to_mode) begin
                spi_end_of_transaction = 1'b1;
                spi_incoming_data = mdata;
            end else begin
                spi_incoming_data = IW'($urandom);
            end
            #1;
            check("no_restart", spi_start_transaction, 0);
            check("slave_hold", spi_slave, 1 << cur_slv);
            check("op_hold", spi_operation, cur_op);
            check("wdata_hold", spi_outgoing_data, cur_dat);
            check("busy_rsp", rsp_valid, 0);
        end
        @(negedge clk);
        spi_end_of_transaction = 1'b0;
        spi_incoming_data = IW'($urandom);
        #1;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_id", rsp_id, g);
        check("rsp_data", rsp_data, (cur_op || to_mode) ? 0 : mdata);
        check("rsp_error", rsp_error, to_mode ? 1 : 0);
        check("busy_resp", busy, 1);
        for (int c = 0; c < G; c++) begin
            @(negedge clk);
            spi_end_of_transaction = ($urandom_range(0, 7) == 0);
            if (rnd && $urandom_range(0, 15) == 0) arm_random_one();
            apply_arms();
            #1;
            check("guard_ready", req_ready, 0);
            check("guard_busy", busy, 1);
            check("guard_slave", spi_slave, 0);
            check("guard_rsp", rsp_valid, 0);
            check("guard_start", spi_start_transaction, 0);
        end
    endtask

    initial begin
        req_valid = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            check("reset_ready", req_ready, 0);
            check("reset_busy", busy, 0);
            check("reset_enable", spi_enable, 0);
            check("reset_rsp", {rsp_valid, rsp_error, rsp_id, rsp_data}, 0);
            check("reset_spi", {spi_start_transaction, spi_slave, spi_operation, spi_outgoing_data}, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        req_valid = '0;

        arm(0, 1'b1, 1, 16'hA55A);
        run_txn(0, 0, 0, 0, -1);
        arm(2, 1'b0, 2, 16'h0000);
        run_txn(0, 0, 0, 0, 8'h3C);
        arm(1, 1'b0, 3, 16'h1111);
        run_txn(0, 0, 0, 0, -1);
        arm(1, 1'b1, 0, 16'h2222);
        run_txn(0, 0, 1, 0, -1);

        for (int i = 0; i < N; i++) arm(i, 1'($urandom_range(0, 1)), $urandom_range(0, NS - 1), OW'($urandom));
        for (int t = 0; t < 5; t++) run_txn(1, 0, 0, 0, -1);
        for (int t = 0; t < 8 && req_valid != 0; t++) run_txn(0, 0, 0, 0, -1);

        for (int t = 0; t < 25; t++) run_txn(0, 1, 0, 0, -1);
        for (int t = 0; t < 8 && (req_valid | arm_mask) != 0; t++) run_txn(0, 0, 0, 0, -1);

`ifdef QUICK_SPI_ARBITER_TIMEOUT_EN
        arm(3, 1'b0, 2, 16'h0F0F);
        run_txn(0, 0, 0, 1, -1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
